// File: rtl/mfp_mac_par.sv
// Pipelined, fully parallel fixed-point dot product over ArrL element pairs.
// Each product is rounded to PordW_ROUND-In1W fractional bits and saturated.
// The rounded products are summed in a binary adder tree that is wide enough
// never to overflow. The sum is rounded back to an integer, saturated to
// AccW_ROUND bits and registered. All registers advance only when en=1.
module mfp_mac_par #(
  parameter int unsigned In1W         = 9,
  parameter int unsigned In2W         = In1W,
  parameter int unsigned ArrL         = 19,
  parameter int unsigned PordW_ROUND  = In1W + 2,
  parameter int unsigned AccW_ROUND   = In1W,
  parameter int unsigned pipeInterval = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [In1W*ArrL-1:0]         in1,
  input  logic [In2W*ArrL-1:0]         in2,
  output logic signed [AccW_ROUND-1:0] out
);

  localparam int unsigned ProdW  = In1W + In2W;
  localparam int unsigned FracP  = PordW_ROUND - In1W;
  // Bits dropped when going from In2W-1 to FracP fractional bits; must be >= 1.
  localparam int unsigned PShift = In2W - 1 - FracP;
  localparam int unsigned D      = (ArrL > 1) ? $clog2(ArrL) : 0;
  localparam int unsigned SumW   = PordW_ROUND + D;

  // Product rounding constants, one guard bit above the full product width.
  localparam logic signed [ProdW:0] PHalf = (ProdW + 1)'(1 << (PShift - 1));
  localparam logic signed [ProdW:0] PMax  =
      {{(ProdW + 2 - PordW_ROUND){1'b0}}, {(PordW_ROUND - 1){1'b1}}};
  localparam logic signed [ProdW:0] PMin  = ~PMax;

  // Output rounding constants, one guard bit above the tree width.
  localparam logic signed [SumW:0] AMax =
      {{(SumW + 2 - AccW_ROUND){1'b0}}, {(AccW_ROUND - 1){1'b1}}};
  localparam logic signed [SumW:0] AMin = ~AMax;

  // Number of operands present at a given tree level.
  function automatic int unsigned node_cnt(input int unsigned lvl);
    int unsigned n;
    n = ArrL;
    for (int unsigned i = 0; i < lvl; i++) n = (n + 1) / 2;
    return n;
  endfunction

  logic signed [PordW_ROUND-1:0] prod_d [ArrL];
  logic signed [PordW_ROUND-1:0] prod_q [ArrL];

  // Per-element multiply, round-half-up and saturate.
  for (genvar i = 0; i < ArrL; i++) begin : g_prod
    logic signed [In1W-1:0] a;
    logic signed [In2W-1:0] b;
    logic signed [ProdW:0]  p;
    logic signed [ProdW:0]  pr;

    assign a  = in1[i*In1W +: In1W];
    assign b  = in2[i*In2W +: In2W];
    assign p  = (ProdW + 1)'(a) * (ProdW + 1)'(b);
    assign pr = (p + PHalf) >>> PShift;

    // Clamp the rounded product to the signed PordW_ROUND range.
    always_comb begin
      prod_d[i] = pr[PordW_ROUND-1:0];
      if (pr > PMax) begin
        prod_d[i] = PMax[PordW_ROUND-1:0];
      end else if (pr < PMin) begin
        prod_d[i] = PMin[PordW_ROUND-1:0];
      end
    end
  end

  // Product register stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q <= '{default: '0};
    end else if (en) begin
      prod_q <= prod_d;
    end
  end

  // Level l operands as seen by level l+1 (registered or combinational).
  logic signed [SumW-1:0] lvl_src [D+1][ArrL];

  for (genvar j = 0; j < ArrL; j++) begin : g_lvl0
    assign lvl_src[0][j] = SumW'(prod_q[j]);
  end

  for (genvar l = 1; l <= D; l++) begin : g_lvl
    localparam int unsigned NIn  = node_cnt(l - 1);
    localparam int unsigned NOut = node_cnt(l);
    localparam bit          Reg  = ((l % pipeInterval) == 0) || (l == D);

    for (genvar j = 0; j < ArrL; j++) begin : g_node
      if (j < NOut) begin : g_used
        logic signed [SumW-1:0] sum;
        // Odd leftover operand passes straight through.
        if (2 * j + 1 < NIn) begin : g_add
          assign sum = lvl_src[l-1][2*j] + lvl_src[l-1][2*j+1];
        end else begin : g_pass
          assign sum = lvl_src[l-1][2*j];
        end

        if (Reg) begin : g_reg
          logic signed [SumW-1:0] sum_q;
          // Tree pipeline register after this level.
          always_ff @(posedge clk) begin
            if (rst) begin
              sum_q <= '0;
            end else if (en) begin
              sum_q <= sum;
            end
          end
          assign lvl_src[l][j] = sum_q;
        end else begin : g_comb
          assign lvl_src[l][j] = sum;
        end
      end else begin : g_unused
        assign lvl_src[l][j] = '0;
      end
    end
  end

  logic signed [SumW:0]         acc_r;
  logic signed [AccW_ROUND-1:0] out_d;

  if (FracP > 0) begin : g_out_rnd
    localparam logic signed [SumW:0] AHalf = (SumW + 1)'(1 << (FracP - 1));
    assign acc_r = ((SumW + 1)'(lvl_src[D][0]) + AHalf) >>> FracP;
  end else begin : g_out_nornd
    assign acc_r = (SumW + 1)'(lvl_src[D][0]);
  end

  // Clamp the rounded sum to the signed output range.
  always_comb begin
    out_d = acc_r[AccW_ROUND-1:0];
    if (acc_r > AMax) begin
      out_d = AMax[AccW_ROUND-1:0];
    end else if (acc_r < AMin) begin
      out_d = AMin[AccW_ROUND-1:0];
    end
  end

  // Output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      out <= '0;
    end else if (en) begin
      out <= out_d;
    end
  end

endmodule

// File: tb/tb_mfp_mac_par.sv
// Directed self-checking bench for mfp_mac_par at default parameters (L=4).
module tb_mfp_mac_par;

  localparam int In1W = 9;
  localparam int In2W = 9;
  localparam int ArrL = 19;
  localparam int AccW = 9;

  logic                         clk;
  logic                         rst;
  logic                         en;
  logic [In1W*ArrL-1:0]         in1;
  logic [In2W*ArrL-1:0]         in2;
  logic signed [AccW-1:0]       out;

  int checks;
  int failures;

  mfp_mac_par dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .in1 (in1),
    .in2 (in2),
    .out (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in1_all(input int v);
    for (int i = 0; i < ArrL; i++) in1[i*In1W +: In1W] = In1W'(v);
  endtask

  task automatic set_in2_all(input int v);
    for (int i = 0; i < ArrL; i++) in2[i*In2W +: In2W] = In2W'(v);
  endtask

  task automatic set_in2_centre(input int v);
    set_in2_all(0);
    in2[9*In2W +: In2W] = In2W'(v);
  endtask

  task automatic set_in2_gauss();
    int g [ArrL];
    g = '{0, 0, 0, 0, 0, 3, 11, 29, 52, 64, 52, 29, 11, 3, 0, 0, 0, 0, 0};
    for (int i = 0; i < ArrL; i++) in2[i*In2W +: In2W] = In2W'(g[i]);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en  = 1'b1;
    set_in1_all(0);
    set_in2_all(0);
    tick();
    tick();
    checks++;
    if (out !== 9'sd0) begin
      failures++;
      $display("FAIL reset_value got=%0d want=0", out);
    end
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if (out !== 9'sd0) begin
        failures++;
        $display("FAIL zero_input cycle=%0d got=%0d want=0", c, out);
      end
    end
  endtask

  task automatic test_gauss();
    set_in1_all(100);
    set_in2_gauss();
    for (int c = 1; c <= 4; c++) begin
      tick();
      checks++;
      if (c < 4 && out !== 9'sd0) begin
        failures++;
        $display("FAIL gauss_latency edge=%0d got=%0d want=0", c, out);
      end else if (c == 4 && out !== 9'sd99) begin
        failures++;
        $display("FAIL gauss_value got=%0d want=99", out);
      end
    end
  endtask

  task automatic test_centre_tap();
    set_in1_all(255);
    set_in2_centre(255);
    repeat (4) tick();
    checks++;
    if (out !== 9'sd254) begin
      failures++;
      $display("FAIL centre_pos got=%0d want=254", out);
    end
    set_in2_centre(-256);
    repeat (4) tick();
    checks++;
    if (out !== -9'sd255) begin
      failures++;
      $display("FAIL centre_neg got=%0d want=-255", out);
    end
  endtask

  task automatic test_saturation();
    set_in1_all(255);
    set_in2_all(255);
    repeat (4) tick();
    checks++;
    if (out !== 9'sd255) begin
      failures++;
      $display("FAIL sat_pos got=%0d want=255", out);
    end
    set_in2_all(-256);
    repeat (4) tick();
    checks++;
    if (out !== -9'sd256) begin
      failures++;
      $display("FAIL sat_neg got=%0d want=-256", out);
    end
  endtask

  task automatic test_stall();
    // Start from a cleared pipeline so the held value is known.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_in1_all(100);
    set_in2_gauss();
    en = 1'b1;
    repeat (2) tick();
    checks++;
    if (out !== 9'sd0) begin
      failures++;
      $display("FAIL stall_early got=%0d want=0", out);
    end
    en = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (out !== 9'sd0) begin
        failures++;
        $display("FAIL stall_hold_zero cycle=%0d got=%0d want=0", c, out);
      end
    end
    en = 1'b1;
    tick();
    checks++;
    if (out !== 9'sd0) begin
      failures++;
      $display("FAIL stall_third_edge got=%0d want=0", out);
    end
    tick();
    checks++;
    if (out !== 9'sd99) begin
      failures++;
      $display("FAIL stall_fourth_edge got=%0d want=99", out);
    end
    // A non-zero result must also hold while en is low.
    en = 1'b0;
    set_in1_all(0);
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (out !== 9'sd99) begin
        failures++;
        $display("FAIL stall_hold_value cycle=%0d got=%0d want=99", c, out);
      end
    end
    en = 1'b1;
  endtask

  task automatic test_back_to_back();
    int exp_v;
    set_in2_centre(255);
    for (int c = 0; c < 14; c++) begin
      set_in1_all(c < 10 ? c : 0);
      tick();
      if (c >= 3) begin
        exp_v = (c - 3 < 10) ? c - 3 : 0;
        checks++;
        if (out !== AccW'(exp_v)) begin
          failures++;
          $display("FAIL stream edge=%0d got=%0d want=%0d", c, out, exp_v);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    set_in1_all(255);
    set_in2_all(255);
    repeat (4) tick();
    checks++;
    if (out !== 9'sd255) begin
      failures++;
      $display("FAIL midrst_fill got=%0d want=255", out);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (out !== 9'sd0) begin
      failures++;
      $display("FAIL midrst_clear got=%0d want=0", out);
    end
    rst = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      tick();
      checks++;
      if (c < 4 && out !== 9'sd0) begin
        failures++;
        $display("FAIL midrst_refill edge=%0d got=%0d want=0", c, out);
      end else if (c == 4 && out !== 9'sd255) begin
        failures++;
        $display("FAIL midrst_result got=%0d want=255", out);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    en       = 1'b0;
    in1      = '0;
    in2      = '0;
    test_reset();
    test_gauss();
    test_centre_tap();
    test_saturation();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
